// File: rtl/text_pkg.sv
// Shared widths and FSM state type for the text-to-word packing path.
package text_pkg;

   localparam int unsigned CHAR_W         = 8;
   localparam int unsigned WORD_W         = 24;
   localparam int unsigned CHARS_PER_WORD = 3;

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } pack_state_t;

endpackage

// File: rtl/char_packer_hold_timer.sv
// 8-bit loadable down-counter; stops at zero and flags it.
module hold_timer (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic       en,
   input  logic [7:0] load_val,
   output logic       zero
);

   logic [7:0] count;

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en && (count != '0)) begin
         count <= count - 8'd1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/char_packer.sv
// Packs up to three characters into a 24-bit word and holds it on the
// channel for HOLD_CYCLES cycles; short final words are padded with PAD_CHAR.
module char_packer
   import text_pkg::*;
#(
   parameter int unsigned        HOLD_CYCLES = 15,
   parameter logic [CHAR_W-1:0]  PAD_CHAR    = 8'h00
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [CHAR_W-1:0] char_in,
   input  logic              char_valid,
   input  logic              char_last,
   output logic              char_ready,
   output logic [WORD_W-1:0] word_out,
   output logic              word_valid,
   output logic              word_last,
   output logic              busy
);

   localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
   localparam logic [1:0] FULL_IDX  = 2'(CHARS_PER_WORD - 1);

   pack_state_t       state;
   pack_state_t       state_next;
   logic [1:0]        fill_cnt;
   logic [CHAR_W-1:0] char_buf [CHARS_PER_WORD];
   logic [WORD_W-1:0] word_next;
   logic              accept;
   logic              word_done;
   logic              timer_load;
   logic              timer_en;
   logic              timer_zero;

   hold_timer u_hold_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (timer_load),
      .en       (timer_en),
      .load_val (HOLD_LOAD),
      .zero     (timer_zero)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= FILL;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      word_done  = 1'b0;
      timer_load = 1'b0;
      timer_en   = 1'b0;
      unique case (state)
         FILL: begin
            accept = char_valid;
            if (char_valid && ((fill_cnt == FULL_IDX) || char_last)) begin
               word_done  = 1'b1;
               timer_load = 1'b1;
               state_next = HOLD;
            end
         end
         HOLD: begin
            timer_en = 1'b1;
            if (timer_zero) begin
               state_next = FILL;
            end
         end
         default: state_next = FILL;
      endcase
   end

   assign char_ready = (state == FILL);
   assign busy       = (state == HOLD) || (fill_cnt != '0);

   // Slots below the fill count come from the buffer, the current slot from
   // char_in, and anything beyond it is padding.
   always_comb begin
      int unsigned fill_n;
      word_next = '0;
      fill_n    = 32'(fill_cnt);
      for (int unsigned i = 0; i < CHARS_PER_WORD; i++) begin
         if (i < fill_n) begin
            word_next[i*CHAR_W +: CHAR_W] = char_buf[i[1:0]];
         end else if (i == fill_n) begin
            word_next[i*CHAR_W +: CHAR_W] = char_in;
         end else begin
            word_next[i*CHAR_W +: CHAR_W] = PAD_CHAR;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fill_cnt   <= '0;
         char_buf   <= '{default: '0};
         word_out   <= '0;
         word_valid <= 1'b0;
         word_last  <= 1'b0;
      end else begin
         if (word_done) begin
            word_out  <= word_next;
            word_last <= char_last;
            fill_cnt  <= '0;
         end else if (accept) begin
            char_buf[fill_cnt] <= char_in;
            fill_cnt           <= fill_cnt + 2'd1;
         end
         word_valid <= (state_next == HOLD);
      end
   end

endmodule

// File: tb/tb_char_packer.sv
// Directed bench for char_packer: default, padded and single-cycle-hold instances.
module tb_char_packer;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  char_in;
   logic        char_last;
   logic        v_main, v_pad, v_h1;

   logic        rdy_m, wv_m, wl_m, busy_m;
   logic [23:0] wo_m;
   logic        rdy_p, wv_p, wl_p, busy_p;
   logic [23:0] wo_p;
   logic        rdy_h, wv_h, wl_h, busy_h;
   logic [23:0] wo_h;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   always #5 clk = ~clk;

   char_packer dut (
      .clk(clk), .reset(reset), .char_in(char_in), .char_valid(v_main),
      .char_last(char_last), .char_ready(rdy_m), .word_out(wo_m),
      .word_valid(wv_m), .word_last(wl_m), .busy(busy_m)
   );

   char_packer #(.HOLD_CYCLES(15), .PAD_CHAR(8'h20)) dut_pad (
      .clk(clk), .reset(reset), .char_in(char_in), .char_valid(v_pad),
      .char_last(char_last), .char_ready(rdy_p), .word_out(wo_p),
      .word_valid(wv_p), .word_last(wl_p), .busy(busy_p)
   );

   char_packer #(.HOLD_CYCLES(1)) dut_h1 (
      .clk(clk), .reset(reset), .char_in(char_in), .char_valid(v_h1),
      .char_last(char_last), .char_ready(rdy_h), .word_out(wo_h),
      .word_valid(wv_h), .word_last(wl_h), .busy(busy_h)
   );

   function automatic logic ready_of(input int unsigned sel);
      return (sel == 0) ? rdy_m : (sel == 1) ? rdy_p : rdy_h;
   endfunction

   // Presents one character to the selected instance and returns #1 after the accepting edge.
   task automatic send(input int unsigned sel, input logic [7:0] c, input logic last);
      int unsigned n = 0;
      char_in   = c;
      char_last = last;
      v_main    = (sel == 0);
      v_pad     = (sel == 1);
      v_h1      = (sel == 2);
      while (!ready_of(sel) && n < 200) begin
         @(negedge clk);
         n++;
      end
      n_cmp++;
      if (ready_of(sel) !== 1'b1) begin
         n_bad++;
         $display("FAIL send_ready: char_ready=%b want 1 (inst %0d)", ready_of(sel), sel);
      end
      @(posedge clk);
      #1;
      v_main = 1'b0;
      v_pad  = 1'b0;
      v_h1   = 1'b0;
   endtask

   task automatic wait_ready(input int unsigned sel);
      int unsigned n = 0;
      while (!ready_of(sel) && n < 200) begin
         @(negedge clk);
         n++;
      end
      n_cmp++;
      if (ready_of(sel) !== 1'b1) begin
         n_bad++;
         $display("FAIL wait_ready: char_ready=%b want 1 (inst %0d)", ready_of(sel), sel);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; v_main = 0; v_pad = 0; v_h1 = 0; char_in = '0; char_last = 0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (wo_m !== 24'h0)  begin n_bad++; $display("FAIL rst_word: got %h want 000000", wo_m); end
      n_cmp++; if (wv_m !== 1'b0)   begin n_bad++; $display("FAIL rst_valid: got %b want 0", wv_m); end
      n_cmp++; if (wl_m !== 1'b0)   begin n_bad++; $display("FAIL rst_last: got %b want 0", wl_m); end
      n_cmp++; if (rdy_m !== 1'b1)  begin n_bad++; $display("FAIL rst_ready: got %b want 1", rdy_m); end
      n_cmp++; if (busy_m !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy_m); end
      n_cmp++; if (wv_h !== 1'b0)   begin n_bad++; $display("FAIL rst_valid_h1: got %b want 0", wv_h); end
      reset = 1'b0;
   endtask

   task automatic test_basic();
      int unsigned cnt = 0;
      send(0, 8'h61, 1'b0);
      n_cmp++; if (busy_m !== 1'b1) begin n_bad++; $display("FAIL basic_busy1: got %b want 1", busy_m); end
      n_cmp++; if (wv_m !== 1'b0)   begin n_bad++; $display("FAIL basic_novalid: got %b want 0", wv_m); end
      send(0, 8'h62, 1'b0);
      send(0, 8'h63, 1'b1);
      n_cmp++; if (wv_m !== 1'b1)       begin n_bad++; $display("FAIL basic_rise: got %b want 1", wv_m); end
      n_cmp++; if (wo_m !== 24'h636261) begin n_bad++; $display("FAIL basic_word: got %h want 636261", wo_m); end
      n_cmp++; if (wl_m !== 1'b1)       begin n_bad++; $display("FAIL basic_last: got %b want 1", wl_m); end
      n_cmp++; if (rdy_m !== 1'b0)      begin n_bad++; $display("FAIL basic_ready_hold: got %b want 0", rdy_m); end
      while (wv_m === 1'b1 && cnt < 100) begin
         cnt++;
         @(posedge clk);
         #1;
      end
      n_cmp++; if (cnt !== 15)          begin n_bad++; $display("FAIL basic_hold_len: got %0d want 15", cnt); end
      n_cmp++; if (rdy_m !== 1'b1)      begin n_bad++; $display("FAIL basic_ready_after: got %b want 1", rdy_m); end
      n_cmp++; if (wo_m !== 24'h636261) begin n_bad++; $display("FAIL basic_retain: got %h want 636261", wo_m); end
      n_cmp++; if (wl_m !== 1'b1)       begin n_bad++; $display("FAIL basic_last_retain: got %b want 1", wl_m); end
      n_cmp++; if (busy_m !== 1'b0)     begin n_bad++; $display("FAIL basic_busy_idle: got %b want 0", busy_m); end
   endtask

   task automatic test_short();
      send(0, 8'h41, 1'b1);
      n_cmp++; if (wo_m !== 24'h000041) begin n_bad++; $display("FAIL short1_word: got %h want 000041", wo_m); end
      n_cmp++; if (wl_m !== 1'b1)       begin n_bad++; $display("FAIL short1_last: got %b want 1", wl_m); end
      wait_ready(0);
      send(0, 8'h41, 1'b0);
      send(0, 8'h42, 1'b1);
      n_cmp++; if (wo_m !== 24'h004241) begin n_bad++; $display("FAIL short2_word: got %h want 004241", wo_m); end
      wait_ready(0);
      send(1, 8'h41, 1'b1);
      n_cmp++; if (wo_p !== 24'h202041) begin n_bad++; $display("FAIL pad_word: got %h want 202041", wo_p); end
      n_cmp++; if (wl_p !== 1'b1)       begin n_bad++; $display("FAIL pad_last: got %b want 1", wl_p); end
      wait_ready(1);
   endtask

   // char_valid stays high across both holds; stalled characters must not be consumed.
   task automatic test_stream();
      v_main = 1'b1;
      for (int i = 0; i < 6; i++) begin
         int unsigned n = 0;
         char_in   = 8'h31 + 8'(i);
         char_last = (i == 5);
         while (!rdy_m && n < 200) begin
            @(negedge clk);
            n++;
         end
         if (i == 3) begin
            n_cmp++; if (n !== 16) begin n_bad++; $display("FAIL stream_stall: got %0d want 16", n); end
            n_cmp++; if (wo_m !== 24'h333231) begin n_bad++; $display("FAIL stream_stable: got %h want 333231", wo_m); end
         end else if (i == 4) begin
            n_cmp++; if (n !== 0) begin n_bad++; $display("FAIL stream_nostall: got %0d want 0", n); end
         end
         @(posedge clk);
         #1;
         if (i == 2) begin
            n_cmp++; if (wo_m !== 24'h333231) begin n_bad++; $display("FAIL stream_w0: got %h want 333231", wo_m); end
            n_cmp++; if (wl_m !== 1'b0)       begin n_bad++; $display("FAIL stream_w0_last: got %b want 0", wl_m); end
            n_cmp++; if (wv_m !== 1'b1)       begin n_bad++; $display("FAIL stream_w0_valid: got %b want 1", wv_m); end
         end else if (i == 5) begin
            n_cmp++; if (wo_m !== 24'h363534) begin n_bad++; $display("FAIL stream_w1: got %h want 363534", wo_m); end
            n_cmp++; if (wl_m !== 1'b1)       begin n_bad++; $display("FAIL stream_w1_last: got %b want 1", wl_m); end
         end
      end
      v_main = 1'b0;
      wait_ready(0);
   endtask

   task automatic test_reset_mid();
      send(0, 8'h61, 1'b0);
      send(0, 8'h62, 1'b0);
      send(0, 8'h63, 1'b1);
      repeat (6) @(posedge clk);
      #1;
      n_cmp++; if (wv_m !== 1'b1) begin n_bad++; $display("FAIL mid_hold7: got %b want 1", wv_m); end
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      n_cmp++; if (wv_m !== 1'b0)   begin n_bad++; $display("FAIL mid_valid: got %b want 0", wv_m); end
      n_cmp++; if (wo_m !== 24'h0)  begin n_bad++; $display("FAIL mid_word: got %h want 000000", wo_m); end
      n_cmp++; if (rdy_m !== 1'b1)  begin n_bad++; $display("FAIL mid_ready: got %b want 1", rdy_m); end
      send(0, 8'h78, 1'b0);
      send(0, 8'h79, 1'b0);
      send(0, 8'h7A, 1'b1);
      n_cmp++; if (wo_m !== 24'h7A7978) begin n_bad++; $display("FAIL mid_next: got %h want 7a7978", wo_m); end
      wait_ready(0);
      send(0, 8'h55, 1'b0);
      send(0, 8'h56, 1'b0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      n_cmp++; if (busy_m !== 1'b0) begin n_bad++; $display("FAIL partial_discard: got %b want 0", busy_m); end
      send(0, 8'h57, 1'b1);
      n_cmp++; if (wo_m !== 24'h000057) begin n_bad++; $display("FAIL partial_fresh: got %h want 000057", wo_m); end
      wait_ready(0);
      char_in = 8'h58; char_last = 1'b1; v_main = 1'b1; reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0; v_main = 1'b0;
      n_cmp++; if (wv_m !== 1'b0)  begin n_bad++; $display("FAIL prio_valid: got %b want 0", wv_m); end
      n_cmp++; if (wo_m !== 24'h0) begin n_bad++; $display("FAIL prio_word: got %h want 000000", wo_m); end
   endtask

   task automatic test_partial_wait();
      logic seen = 1'b0;
      send(0, 8'h61, 1'b0);
      send(0, 8'h62, 1'b0);
      repeat (500) begin
         @(posedge clk);
         #1;
         if (wv_m !== 1'b0) seen = 1'b1;
      end
      n_cmp++; if (seen !== 1'b0)   begin n_bad++; $display("FAIL wait_novalid: got %b want 0", seen); end
      n_cmp++; if (busy_m !== 1'b1) begin n_bad++; $display("FAIL wait_busy: got %b want 1", busy_m); end
      send(0, 8'h21, 1'b0);
      n_cmp++; if (wo_m !== 24'h216261) begin n_bad++; $display("FAIL wait_word: got %h want 216261", wo_m); end
      n_cmp++; if (wl_m !== 1'b0)       begin n_bad++; $display("FAIL wait_last: got %b want 0", wl_m); end
      wait_ready(0);
   endtask

   task automatic test_hold_one();
      send(2, 8'h61, 1'b0);
      send(2, 8'h62, 1'b0);
      send(2, 8'h63, 1'b1);
      n_cmp++; if (wv_h !== 1'b1)       begin n_bad++; $display("FAIL h1_valid: got %b want 1", wv_h); end
      n_cmp++; if (wo_h !== 24'h636261) begin n_bad++; $display("FAIL h1_word: got %h want 636261", wo_h); end
      @(posedge clk);
      #1;
      n_cmp++; if (wv_h !== 1'b0)  begin n_bad++; $display("FAIL h1_drop: got %b want 0", wv_h); end
      n_cmp++; if (rdy_h !== 1'b1) begin n_bad++; $display("FAIL h1_ready: got %b want 1", rdy_h); end
      send(2, 8'h64, 1'b1);
      n_cmp++; if (wo_h !== 24'h000064) begin n_bad++; $display("FAIL h1_b2b: got %h want 000064", wo_h); end
      n_cmp++; if (wl_h !== 1'b1)       begin n_bad++; $display("FAIL h1_b2b_last: got %b want 1", wl_h); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic();
      test_short();
      test_stream();
      test_reset_mid();
      test_partial_wait();
      test_hold_one();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
